// File: rtl/uart_cmd_pkg.sv
// Shared types and widths for the UART command link.
package uart_cmd_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam int DATA_BITS = 8;
   localparam int CMD_W     = 16;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: RX synchronizer, edge detect and mid-bit sampling FSM.
// rx_done pulses for one cycle with rx_byte when a frame ends in a valid stop bit.
module uart_rx_byte
   import uart_cmd_pkg::*;
#(
   parameter int BAUD_DIV = 868
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_byte,
   output logic                 rx_done,
   output logic                 rx_busy
);

   localparam int CW = $clog2(BAUD_DIV) + 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);

   uart_state_t          state;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_cnt;
   logic [2:0]           sync;
   logic [DATA_BITS-1:0] rx_shift;

   assign rx_busy = (state != IDLE);

   // sync[1] is the synchronized line, sync[2] its previous value for edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         sync     <= 3'b111;
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         rx_shift <= '0;
         rx_byte  <= '0;
         rx_done  <= 1'b0;
      end else begin
         sync    <= {sync[1:0], rx};
         rx_done <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_cnt <= '0;
               if (sync[2] && !sync[1]) state <= START;
            end
            START: begin
               if (cnt == BAUD_HALF) begin
                  cnt   <= '0;
                  state <= sync[1] ? IDLE : DATA;
               end else cnt <= cnt + CW'(1);
            end
            DATA: begin
               if (cnt == BAUD_LAST) begin
                  cnt      <= '0;
                  rx_shift <= {sync[1], rx_shift[DATA_BITS-1:1]};
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                  end else bit_cnt <= bit_cnt + 4'd1;
               end else cnt <= cnt + CW'(1);
            end
            STOP: begin
               if (cnt == BAUD_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (sync[1]) begin
                     rx_byte <= rx_shift;
                     rx_done <= 1'b1;
                  end
               end else cnt <= cnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_cmd_link.sv
// Host UART link: byte pairs on RX become cmd/cmd_rdy, resp is serialized on TX.
// Optional UART_CMD_TIMEOUT_EN drops a stale high byte after TO_BITS idle bit times.
module uart_cmd_link
   import uart_cmd_pkg::*;
#(
   parameter int BAUD_DIV = 868,
   parameter int TO_BITS  = 40
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RX,
   output logic                 TX,
   output logic [CMD_W-1:0]     cmd,
   output logic                 cmd_rdy,
   input  logic                 clr_cmd_rdy,
   input  logic [DATA_BITS-1:0] resp,
   input  logic                 send_resp,
   output logic                 resp_sent,
   output logic                 tx_busy
);

   localparam int CW = $clog2(BAUD_DIV) + 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD_DIV - 2);
   localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);

   logic [DATA_BITS-1:0] rx_byte;
   logic                 rx_done;
   logic                 rx_busy;
   logic [DATA_BITS-1:0] hi_byte;
   logic                 hi_valid;
   logic                 to_expire;

   uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .rx      (RX),
      .rx_byte (rx_byte),
      .rx_done (rx_done),
      .rx_busy (rx_busy)
   );

`ifdef UART_CMD_TIMEOUT_EN
   localparam int TO_CYCLES = TO_BITS * BAUD_DIV;
   localparam int TW = $clog2(TO_CYCLES) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

   logic [TW-1:0] to_cnt;

   // Only idle line time counts toward the gap; a frame in flight pauses it.
   assign to_expire = hi_valid && !rx_busy && (to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst || rx_done || !hi_valid) to_cnt <= '0;
      else if (!rx_busy && to_cnt != TO_LAST) to_cnt <= to_cnt + TW'(1);
   end
`else
   logic timeout_unused;
   assign timeout_unused = rx_busy & (TO_BITS > 0);
   assign to_expire = 1'b0;
`endif

   // Set wins over clr_cmd_rdy because it is assigned last.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd      <= '0;
         cmd_rdy  <= 1'b0;
         hi_byte  <= '0;
         hi_valid <= 1'b0;
      end else begin
         if (clr_cmd_rdy) cmd_rdy <= 1'b0;
         if (rx_done) begin
            if (!hi_valid) begin
               hi_byte  <= rx_byte;
               hi_valid <= 1'b1;
               cmd_rdy  <= 1'b0;
            end else begin
               cmd      <= {hi_byte, rx_byte};
               cmd_rdy  <= 1'b1;
               hi_valid <= 1'b0;
            end
         end else if (to_expire) hi_valid <= 1'b0;
      end
   end

   uart_state_t          tx_state;
   logic [CW-1:0]        tx_cnt;
   logic [3:0]           tx_bit;
   logic [DATA_BITS-1:0] tx_shift;

   // resp_sent is raised one cycle early so it lands on the last stop-bit cycle,
   // where a fresh send_resp may chain straight into the next start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state  <= IDLE;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '0;
         TX        <= 1'b1;
         tx_busy   <= 1'b0;
         resp_sent <= 1'b0;
      end else begin
         resp_sent <= 1'b0;
         case (tx_state)
            IDLE: begin
               tx_cnt <= '0;
               tx_bit <= '0;
               if (send_resp) begin
                  tx_shift <= resp;
                  TX       <= 1'b0;
                  tx_busy  <= 1'b1;
                  tx_state <= START;
               end
            end
            START: begin
               if (tx_cnt == BAUD_LAST) begin
                  tx_cnt   <= '0;
                  TX       <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_state <= DATA;
               end else tx_cnt <= tx_cnt + CW'(1);
            end
            DATA: begin
               if (tx_cnt == BAUD_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == BIT_LAST) begin
                     tx_bit   <= '0;
                     TX       <= 1'b1;
                     tx_state <= STOP;
                  end else begin
                     tx_bit   <= tx_bit + 4'd1;
                     TX       <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                  end
               end else tx_cnt <= tx_cnt + CW'(1);
            end
            STOP: begin
               if (tx_cnt == BAUD_LAST) begin
                  tx_cnt <= '0;
                  if (send_resp) begin
                     tx_shift <= resp;
                     TX       <= 1'b0;
                     tx_state <= START;
                  end else begin
                     TX       <= 1'b1;
                     tx_busy  <= 1'b0;
                     tx_state <= IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt + CW'(1);
                  if (tx_cnt == BAUD_PRE) resp_sent <= 1'b1;
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Self-checking bench for uart_cmd_link: vector table, directed corners and
// randomized frames against a byte-level command/response model.
module tb_uart_cmd_link;

   localparam int B = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RX = 1'b1;
   logic        TX;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        send_resp = 1'b0;
   logic        resp_sent;
   logic        tx_busy;

   int errors = 0;
   int checks = 0;

   // byte-level model of the command assembler
   logic        m_hi_valid;
   logic [7:0]  m_hi;
   logic [15:0] m_cmd;
   logic        m_rdy;

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      logic        clr;
      logic [15:0] exp_cmd;
      logic        exp_rdy;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   uart_cmd_link #(.BAUD_DIV(B), .TO_BITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .RX          (RX),
      .TX          (TX),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .resp        (resp),
      .send_resp   (send_resp),
      .resp_sent   (resp_sent),
      .tx_busy     (tx_busy)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_rx(input logic [7:0] d, input logic ok);
      if (ok) begin
         if (!m_hi_valid) begin
            m_hi = d; m_hi_valid = 1'b1; m_rdy = 1'b0;
         end else begin
            m_cmd = {m_hi, d}; m_rdy = 1'b1; m_hi_valid = 1'b0;
         end
      end
   endtask

   // called on a negedge; every bit is held for B cycles
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap);
      logic [9:0] f;
      f = {stop_bit, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         RX = f[i];
         repeat (B) @(negedge clk);
      end
      RX = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   // stops one cycle before the end of the stop bit
   task automatic send_head(input logic [7:0] d);
      logic [8:0] f;
      f = {d, 1'b0};
      for (int i = 0; i < 9; i++) begin
         RX = f[i];
         repeat (B) @(negedge clk);
      end
      RX = 1'b1;
      repeat (B - 1) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  tx_q[4];
      logic [7:0]  cur;
      logic [7:0]  d;
      logic        ok, exp_tx;
      int          j, gap;

      tbl[0] = '{8'h5A, 1'b1, 1'b0, 16'h0000, 1'b0};
      tbl[1] = '{8'hC3, 1'b1, 1'b1, 16'h5AC3, 1'b1};
      tbl[2] = '{8'h77, 1'b1, 1'b0, 16'h5AC3, 1'b0};
      tbl[3] = '{8'h55, 1'b0, 1'b0, 16'h5AC3, 1'b0};
      tbl[4] = '{8'h12, 1'b1, 1'b0, 16'h7712, 1'b1};
      tbl[5] = '{8'hFF, 1'b1, 1'b0, 16'h7712, 1'b0};
      tbl[6] = '{8'h00, 1'b1, 1'b1, 16'hFF00, 1'b1};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_tx", TX, 1);
      chk("reset_cmd", cmd, 0);
      chk("reset_cmd_rdy", cmd_rdy, 0);
      chk("reset_resp_sent", resp_sent, 0);
      chk("reset_tx_busy", tx_busy, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         send_frame(tbl[i].data, tbl[i].stop, 4);
         chk($sformatf("tbl%0d_cmd", i), cmd, tbl[i].exp_cmd);
         chk($sformatf("tbl%0d_rdy", i), cmd_rdy, tbl[i].exp_rdy);
         if (tbl[i].clr) begin
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            chk($sformatf("tbl%0d_clr", i), cmd_rdy, 0);
         end
      end

      // exact cmd_rdy timing around the low byte's stop sample
      send_frame(8'hA5, 1'b1, 4);
      send_head(8'h3C);
      chk("rdy_before_stop_sample", cmd_rdy, 0);
      @(negedge clk);
      chk("rdy_after_stop_sample", cmd_rdy, 1);
      chk("cmd_A53C", cmd, 16'hA53C);
      repeat (20) @(negedge clk);
      chk("rdy_held", cmd_rdy, 1);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      chk("rdy_cleared", cmd_rdy, 0);
      chk("cmd_kept_after_clr", cmd, 16'hA53C);

      // clear coinciding with pair completion
      send_frame(8'h9E, 1'b1, 4);
      send_head(8'h4D);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      chk("set_wins_rdy", cmd_rdy, 1);
      chk("set_wins_cmd", cmd, 16'h9E4D);

      // short low glitch between high and low bytes
      send_frame(8'h12, 1'b1, 4);
      RX = 1'b0;
      repeat (2) @(negedge clk);
      RX = 1'b1;
      repeat (12) @(negedge clk);
      chk("glitch_cmd", cmd, 16'h9E4D);
      chk("glitch_rdy", cmd_rdy, 0);
      send_frame(8'h34, 1'b1, 4);
      chk("after_glitch_cmd", cmd, 16'h1234);
      chk("after_glitch_rdy", cmd_rdy, 1);

      // long gap after a high byte
      send_frame(8'h11, 1'b1, 40);
      send_frame(8'h22, 1'b1, 4);
      send_frame(8'h33, 1'b1, 4);
`ifdef UART_CMD_TIMEOUT_EN
      chk("gap_cmd", cmd, 16'h2233);
      chk("gap_rdy", cmd_rdy, 1);
`else
      chk("gap_cmd", cmd, 16'h1122);
      chk("gap_rdy", cmd_rdy, 0);
`endif

      // reset mid TX frame discards pending high byte too
      send_frame(8'hAB, 1'b1, 2);
      resp = 8'h00;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      repeat (19) @(negedge clk);
      chk("tx_low_before_reset", TX, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_tx_high", TX, 1);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_cmd", cmd, 0);
      chk("rst_cmd_rdy", cmd_rdy, 0);
      @(negedge clk);
      send_frame(8'hCD, 1'b1, 4);
      send_frame(8'hEF, 1'b1, 4);
      chk("post_rst_cmd", cmd, 16'hCDEF);
      chk("post_rst_rdy", cmd_rdy, 1);

      // TX: C3 then random bytes chained on resp_sent; extra send at cycle 40 ignored
      tx_q[0] = 8'hC3;
      for (int f = 1; f < 4; f++) tx_q[f] = 8'($urandom);
      resp = tx_q[0];
      send_resp = 1'b1;
      for (int f = 0; f < 4; f++) begin
         cur = tx_q[f];
         for (int k = 1; k <= 10 * B; k++) begin
            @(negedge clk);
            j = (k - 1) / B;
            if (j == 0) exp_tx = 1'b0;
            else if (j == 9) exp_tx = 1'b1;
            else exp_tx = cur[j-1];
            chk($sformatf("tx_line f%0d c%0d", f, k), TX, exp_tx);
            chk($sformatf("tx_busy f%0d c%0d", f, k), tx_busy, 1);
            chk($sformatf("resp_sent f%0d c%0d", f, k), resp_sent, (k == 10 * B));
            send_resp = 1'b0;
            if (k == 40) begin
               send_resp = 1'b1;
               resp = ~cur;
            end else if (k == 10 * B && f < 3) begin
               send_resp = 1'b1;
               resp = tx_q[f+1];
            end
         end
      end
      @(negedge clk);
      chk("tx_idle_line", TX, 1);
      chk("tx_idle_busy", tx_busy, 0);
      chk("tx_idle_resp_sent", resp_sent, 0);

      // random RX frames against the model
      m_hi_valid = 1'b0; m_hi = 8'h00; m_cmd = 16'hCDEF; m_rdy = 1'b1;
      for (int n = 0; n < 14; n++) begin
         d = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         gap = $urandom_range(2, 10);
         send_frame(d, ok, gap);
         model_rx(d, ok);
         chk($sformatf("rand%0d_cmd", n), cmd, m_cmd);
         chk($sformatf("rand%0d_rdy", n), cmd_rdy, m_rdy);
         if ($urandom_range(0, 3) == 0) begin
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            m_rdy = 1'b0;
            chk($sformatf("rand%0d_clr", n), cmd_rdy, m_rdy);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
